// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bundle: hazard inputs from ID/EX and stall/bubble controls back to the pipeline.
// Statistics ports exist only when HAZARD_STATS_EN is defined.
interface hazard_stall_unit_if;
    logic [4:0] rsId;
    logic [4:0] rtId;
    logic       useRsId;
    logic       useRtId;
    logic [4:0] fsId;
    logic [4:0] ftId;
    logic       useFsId;
    logic       useFtId;
    logic [4:0] rWEx;
    logic       memReadEx;
    logic       fpLoadEx;
    logic [1:0] fpOpEx;

    logic       pcWrite;
    logic       ifIdWrite;
    logic       idExWrite;
    logic       idExBubble;
    logic       exMemBubble;
    logic       fpBusy;
`ifdef HAZARD_STATS_EN
    logic [31:0] loadStallCnt;
    logic [31:0] fpStallCnt;
`endif

    modport master (
`ifdef HAZARD_STATS_EN
        input  loadStallCnt, fpStallCnt,
`endif
        output rsId, rtId, useRsId, useRtId, fsId, ftId, useFsId, useFtId,
        output rWEx, memReadEx, fpLoadEx, fpOpEx,
        input  pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble, fpBusy
    );

    modport slave (
`ifdef HAZARD_STATS_EN
        output loadStallCnt, fpStallCnt,
`endif
        input  rsId, rtId, useRsId, useRtId, fsId, ftId, useFsId, useFtId,
        input  rWEx, memReadEx, fpLoadEx, fpOpEx,
        output pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble, fpBusy
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use and multicycle-FP hazard controller driving PC, IF/ID, ID/EX and EX/MEM enables/bubbles.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned FP_ADD_LAT = 2,
    parameter int unsigned FP_MUL_LAT = 4,
    parameter int unsigned FP_DIV_LAT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_unit_if.slave io_hz
);

    typedef enum logic [0:0] {StIdle, StFpBusy} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fp_busy;

    logic [CNT_W-1:0] w_lat_m1;
    logic             w_fp_start;
    logic             w_busy_freeze;
    logic             w_int_hit;
    logic             w_fp_hit;
    logic             w_load_use;
    logic             w_load_bubble;
    logic             w_freeze;

    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_id_ex_write;
    logic             w_id_ex_bubble;
    logic             w_ex_mem_bubble;

    // Counter is loaded with lat-1: the start cycle itself is the first EX-occupancy cycle.
    always_comb begin
        w_lat_m1 = '0;
        unique case (io_hz.fpOpEx)
            2'b01:   w_lat_m1 = CNT_W'(FP_ADD_LAT - 1);
            2'b10:   w_lat_m1 = CNT_W'(FP_MUL_LAT - 1);
            2'b11:   w_lat_m1 = CNT_W'(FP_DIV_LAT - 1);
            default: w_lat_m1 = '0;
        endcase
    end

    assign w_fp_start = (r_state == StIdle) && (io_hz.fpOpEx != 2'b00) && (w_lat_m1 != '0);
    assign w_busy_freeze = (r_state == StFpBusy) && (r_cnt > CntOne);

    assign w_int_hit = io_hz.memReadEx && (io_hz.rWEx != 5'd0) &&
                       ((io_hz.useRsId && (io_hz.rsId == io_hz.rWEx)) ||
                        (io_hz.useRtId && (io_hz.rtId == io_hz.rWEx)));

    // FP register 0 is an ordinary register, so no zero exclusion on this path.
    assign w_fp_hit = io_hz.fpLoadEx &&
                      ((io_hz.useFsId && (io_hz.fsId == io_hz.rWEx)) ||
                       (io_hz.useFtId && (io_hz.ftId == io_hz.rWEx)));

    assign w_load_use    = w_int_hit || w_fp_hit;
    assign w_load_bubble = rst_n && (r_state == StIdle) && !w_fp_start && w_load_use;
    assign w_freeze      = rst_n && (w_fp_start || w_busy_freeze);

    always_comb begin
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_id_ex_write   = 1'b1;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        if (!rst_n) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b0;
            w_id_ex_bubble  = 1'b0;
            w_ex_mem_bubble = 1'b1;
        end else if (w_load_bubble) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_fp_busy <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_fp_start) begin
                        r_state   <= StFpBusy;
                        r_cnt     <= w_lat_m1;
                        r_fp_busy <= 1'b1;
                    end
                end
                StFpBusy: begin
                    // cnt==1 is the release cycle; fpOpEx here still belongs to the finishing op.
                    if (r_cnt > CntOne) begin
                        r_cnt <= r_cnt - CntOne;
                    end else begin
                        r_state   <= StIdle;
                        r_cnt     <= '0;
                        r_fp_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_cnt     <= '0;
                    r_fp_busy <= 1'b0;
                end
            endcase
        end
    end

    assign io_hz.pcWrite     = w_pc_write;
    assign io_hz.ifIdWrite   = w_if_id_write;
    assign io_hz.idExWrite   = w_id_ex_write;
    assign io_hz.idExBubble  = w_id_ex_bubble;
    assign io_hz.exMemBubble = w_ex_mem_bubble;
    assign io_hz.fpBusy      = r_fp_busy && rst_n;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_load_stall_cnt;
    logic [31:0] r_fp_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_stall_cnt <= '0;
            r_fp_stall_cnt   <= '0;
        end else begin
            if (w_load_bubble && (r_load_stall_cnt != 32'hFFFF_FFFF)) begin
                r_load_stall_cnt <= r_load_stall_cnt + 32'd1;
            end
            if (w_freeze && (r_fp_stall_cnt != 32'hFFFF_FFFF)) begin
                r_fp_stall_cnt <= r_fp_stall_cnt + 32'd1;
            end
        end
    end

    assign io_hz.loadStallCnt = r_load_stall_cnt;
    assign io_hz.fpStallCnt   = r_fp_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (ADD=2, MUL=4, DIV=16).
// Inputs change just after negedge; outputs sampled 1ns later, well before the next posedge.
module tb_hazard_stall_unit;

    // {pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble, fpBusy}
    localparam logic [5:0] PRst  = 6'b001110;
    localparam logic [5:0] PNorm = 6'b111000;
    localparam logic [5:0] PLoad = 6'b001100;
    localparam logic [5:0] PFrzI = 6'b000010;
    localparam logic [5:0] PFrzB = 6'b000011;
    localparam logic [5:0] PRel  = 6'b111001;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if hz ();

    hazard_stall_unit #(
        .FP_ADD_LAT (2),
        .FP_MUL_LAT (4),
        .FP_DIV_LAT (16),
        .CNT_W      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_hz (hz)
    );

    task automatic clear_inputs();
        hz.rsId = 5'd0; hz.rtId = 5'd0; hz.useRsId = 1'b0; hz.useRtId = 1'b0;
        hz.fsId = 5'd0; hz.ftId = 5'd0; hz.useFsId = 1'b0; hz.useFtId = 1'b0;
        hz.rWEx = 5'd0; hz.memReadEx = 1'b0; hz.fpLoadEx = 1'b0; hz.fpOpEx = 2'b00;
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        #1;
        obs = {hz.pcWrite, hz.ifIdWrite, hz.idExWrite, hz.idExBubble, hz.exMemBubble, hz.fpBusy};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        @(negedge clk);
    endtask

`ifdef HAZARD_STATS_EN
    task automatic check_stats(input string tag, input logic [31:0] exp_load,
                               input logic [31:0] exp_fp);
        n_checks++;
        assert (hz.loadStallCnt === exp_load) n_pass++;
        else $error("FAIL %s_load: observed %0d expected %0d", tag, hz.loadStallCnt, exp_load);
        n_checks++;
        assert (hz.fpStallCnt === exp_fp) n_pass++;
        else $error("FAIL %s_fp: observed %0d expected %0d", tag, hz.fpStallCnt, exp_fp);
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        hz.fpOpEx = 2'b11;
        check_ctl("rst_c0", PRst);
        check_ctl("rst_c1", PRst);

        // Divide starts on the first IDLE evaluation, then reset aborts it at freeze cycle 7.
        rst_n = 1'b1;
        check_ctl("div_start", PFrzI);
        for (int i = 2; i <= 6; i++) check_ctl($sformatf("div_busy%0d", i), PFrzB);
        rst_n = 1'b0;
        check_ctl("div_abort_rst", PRst);
        rst_n = 1'b1;
        hz.fpOpEx = 2'b00;
        for (int i = 0; i < 16; i++) check_ctl($sformatf("post_abort%0d", i), PNorm);
`ifdef HAZARD_STATS_EN
        check_stats("stats_cleared", 32'd0, 32'd0);
`endif

        // Integer load-use
        hz.memReadEx = 1'b1; hz.rWEx = 5'd5; hz.useRsId = 1'b1; hz.rsId = 5'd5;
        check_ctl("int_rs_hit", PLoad);
        hz.memReadEx = 1'b0;
        check_ctl("int_nop_in_ex", PNorm);
        hz.memReadEx = 1'b1; hz.rWEx = 5'd0; hz.rsId = 5'd0;
        check_ctl("int_r0_nohit", PNorm);
        hz.rWEx = 5'd7; hz.useRsId = 1'b0; hz.useRtId = 1'b1; hz.rtId = 5'd7;
        check_ctl("int_rt_hit", PLoad);
        hz.rWEx = 5'd5; hz.useRtId = 1'b0; hz.rsId = 5'd5;
        check_ctl("int_unused_src", PNorm);

        // FP load-use
        clear_inputs();
        hz.fpLoadEx = 1'b1; hz.rWEx = 5'd0; hz.useFtId = 1'b1; hz.ftId = 5'd0;
        check_ctl("fp_ft0_hit", PLoad);
        hz.ftId = 5'd3;
        check_ctl("fp_ft_miss", PNorm);
        hz.useFtId = 1'b0; hz.useFsId = 1'b1; hz.fsId = 5'd9; hz.rWEx = 5'd9;
        check_ctl("fp_fs_hit", PLoad);
        hz.useFsId = 1'b0; hz.useRsId = 1'b1; hz.rsId = 5'd9;
        check_ctl("fp_vs_int_file", PNorm);

        // Multiply (lat 4) with a load-use pair present during the busy period, then back-to-back
        clear_inputs();
        hz.fpOpEx = 2'b10;
        check_ctl("mul_start", PFrzI);
        hz.memReadEx = 1'b1; hz.rWEx = 5'd5; hz.useRsId = 1'b1; hz.rsId = 5'd5;
        check_ctl("mul_busy_prio", PFrzB);
        hz.memReadEx = 1'b0; hz.useRsId = 1'b0;
        check_ctl("mul_busy2", PFrzB);
        check_ctl("mul_release", PRel);
        check_ctl("mul2_start", PFrzI);
        hz.fpOpEx = 2'b00;
        check_ctl("mul2_busy1", PFrzB);
        check_ctl("mul2_busy2", PFrzB);
        check_ctl("mul2_release", PRel);
        check_ctl("mul2_done", PNorm);

        // Add (lat 2): one freeze, then release
        hz.fpOpEx = 2'b01;
        check_ctl("add_start", PFrzI);
        check_ctl("add_release", PRel);
        hz.fpOpEx = 2'b00;
`ifdef HAZARD_STATS_EN
        check_stats("stats_final", 32'd4, 32'd7);
`endif
        check_ctl("add_done", PNorm);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller that drives the write-enable and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects integer and FP load-use hazards between the ID and EX stages.
- Freezes the front end while a multicycle FP add, multiply or divide occupies EX, and inserts NOP bubbles downstream.
- Sits in the ID stage beside the register file and control decoder; it is the producer of the ID/EX `write` enable.

Parameters:
- FP_ADD_LAT, 2, total EX-occupancy cycles for an FP add/sub (must be >=1)
- FP_MUL_LAT, 4, total EX-occupancy cycles for an FP multiply (must be >=1)
- FP_DIV_LAT, 16, total EX-occupancy cycles for an FP divide (must be >=1)
- CNT_W, 5, latency counter width; must hold max(LAT)-1

Ports:
- clk  in  1  pipeline clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- rsId  in  5  integer source register A of the instruction in ID
- rtId  in  5  integer source register B of the instruction in ID
- useRsId  in  1  ID instruction reads rsId
- useRtId  in  1  ID instruction reads rtId
- fsId  in  5  FP source register A in ID
- ftId  in  5  FP source register B in ID
- useFsId  in  1  ID instruction reads fsId
- useFtId  in  1  ID instruction reads ftId
- rWEx  in  5  destination register of the instruction in EX
- memReadEx  in  1  EX instruction is an integer load
- fpLoadEx  in  1  EX instruction is an FP load; its destination is rWEx in the FP file
- fpOpEx  in  2  EX FP op class: 00 none, 01 add, 10 mul, 11 div
- pcWrite  out  1  PC update enable
- ifIdWrite  out  1  IF/ID write enable
- idExWrite  out  1  ID/EX write enable
- idExBubble  out  1  zero all ID/EX control fields on this write (NOP)
- exMemBubble  out  1  zero all EX/MEM control fields on this write (NOP)
- fpBusy  out  1  multicycle FP op in progress (registered state != IDLE)

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-low reset `rst_n`.
- Reset:
  - On a posedge with rst_n=0: state<=IDLE, cnt<=0.
  - While rst_n=0 the outputs are pcWrite=0, ifIdWrite=0, idExWrite=1, idExBubble=1, exMemBubble=1, fpBusy=0.
  - Reset mid-FP-op aborts it; no completion is signalled.
- States are IDLE and FP_BUSY. cnt is CNT_W bits.
- lat(fpOpEx): 01->FP_ADD_LAT, 10->FP_MUL_LAT, 11->FP_DIV_LAT, 00->1.
- fpStart = (state==IDLE) && (fpOpEx!=00) && (lat>1).
- IDLE with fpStart:
  - Outputs: pcWrite=0, ifIdWrite=0, idExWrite=0, idExBubble=0, exMemBubble=1.
  - Next state FP_BUSY; cnt<=lat-1.
- FP_BUSY with cnt>1:
  - Outputs: same freeze as above.
  - cnt<=cnt-1.
- FP_BUSY with cnt==1 (release cycle):
  - Outputs: pcWrite=1, ifIdWrite=1, idExWrite=1, idExBubble=0, exMemBubble=0.
  - Next state IDLE; cnt<=0.
  - The op occupies EX for exactly lat cycles in total.
  - fpOpEx is ignored in this cycle, because EX still holds the finishing op.
- Load-use hazard, evaluated only when state==IDLE and not fpStart. loadUse is true when any of:
  - memReadEx && rWEx!=0 && ((useRsId && rsId==rWEx) || (useRtId && rtId==rWEx))
  - fpLoadEx && ((useFsId && fsId==rWEx) || (useFtId && ftId==rWEx)). FP reg 0 is a real register, so there is no zero exclusion here.
- loadUse outputs: pcWrite=0, ifIdWrite=0, idExWrite=1, idExBubble=1, exMemBubble=0. This is a one-cycle bubble; state is unchanged.
- No hazard: pcWrite=1, ifIdWrite=1, idExWrite=1, idExBubble=0, exMemBubble=0.
- Priority: reset > FP_BUSY > fpStart > loadUse > normal.
- In the cycle after a load-use bubble, EX holds the NOP, so the stall never repeats for the same pair.
- lat==1 ops never stall.
- Back-to-back multicycle FP ops: the second enters EX on the release cycle and starts its own stall on the next IDLE cycle, with no gap.
- All outputs except fpBusy are combinational from state, cnt and inputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two extra outputs are added, both cleared by rst_n=0 and saturating at 32'hFFFFFFFF:
  - loadStallCnt (32): +1 per loadUse bubble cycle.
  - fpStallCnt (32): +1 per freeze cycle (fpStart or FP_BUSY with cnt>1).
- When undefined, neither port nor the counters exist and all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with fpOpEx=11 -> idExBubble=1, exMemBubble=1, pcWrite=0, fpBusy=0. Release -> FP_BUSY entered on the next IDLE evaluation.
- Integer load-use: memReadEx=1, rWEx=5, useRsId=1, rsId=5 -> one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1. Repeat with rWEx=0 -> no stall.
- FP load-use: fpLoadEx=1, rWEx=0, useFtId=1, ftId=0 -> one bubble cycle. Then ftId=3 -> no stall.
- FP multiply, FP_MUL_LAT=4: fpOpEx=10 held in EX -> exactly 3 freeze cycles (idExWrite=0, exMemBubble=1), then 1 release cycle; fpBusy high for cycles 2-4.
- FP divide interrupted: fpOpEx=11, rst_n=0 at freeze cycle 7 -> state IDLE and cnt=0 after the edge; no release cycle occurs.
- Priority: FP_BUSY with cnt=3 while memReadEx=1 and a matching rsId -> freeze outputs only, idExBubble=0. With HAZARD_STATS_EN defined, fpStallCnt increments and loadStallCnt does not.
